// File: rtl/gc_rx.sv
// N64/GameCube single-wire receiver: classifies low-pulse widths into bits,
// packs them MSB-first into bytes and reports frame end after the stop bit.
module gc_rx #(
  parameter int CLK_PER_US  = 50,
  parameter int ONE_MAX_CLK = 2 * CLK_PER_US,
  parameter int LOW_MAX_CLK = 5 * CLK_PER_US,
  parameter int IDLE_CLK    = 5 * CLK_PER_US
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_in,
  input  logic       tx_active,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_MAX = (LOW_MAX_CLK > IDLE_CLK) ? LOW_MAX_CLK : IDLE_CLK;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] ONE_MAX  = CW'(ONE_MAX_CLK);
  localparam logic [CW-1:0] LOW_MAX  = CW'(LOW_MAX_CLK);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CLK);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  state_t        state, state_nxt;
  logic          line_p0, line_p1, line_p2;
  logic          line_s, fall;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    sr, sr_nxt, sr_shift, data_nxt;
  logic          bit_val;
  logic          data_valid_nxt, frame_done_nxt, frame_err_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Synchronizer stages p0/p1; p2 holds the previous line_s for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      line_p0 <= line_in;
      line_p1 <= line_p0;
      line_p2 <= line_p1;
    end
  end

  assign line_s   = line_p1;
  assign fall     = !line_p1 && line_p2;
  assign bit_val  = (cnt < ONE_MAX);
  assign sr_shift = {sr[6:0], bit_val};
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_cnt_nxt    = bit_cnt;
    sr_nxt         = sr;
    data_nxt       = data;
    data_valid_nxt = 1'b0;
    frame_done_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    if (tx_active) begin
      state_nxt   = S_IDLE;
      cnt_nxt     = '0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fall) begin
            state_nxt   = S_LOW;
            cnt_nxt     = CNT_ONE;
            bit_cnt_nxt = '0;
          end
        end
        S_LOW: begin
          // An over-long low aborts even if the line rose in this same cycle
          if (cnt >= LOW_MAX) begin
            frame_err_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end else if (line_s) begin
            sr_nxt      = sr_shift;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_nxt       = sr_shift;
              data_valid_nxt = 1'b1;
            end
            cnt_nxt   = CNT_ONE;
            state_nxt = S_HIGH;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        S_HIGH: begin
          // Only a frame of whole bytes plus one stop pulse ends cleanly
          if (cnt >= IDLE_MAX) begin
            if (bit_cnt == 3'd1) frame_done_nxt = 1'b1;
            else                 frame_err_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else if (fall) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = S_LOW;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sr         <= sr_nxt;
      data       <= data_nxt;
      data_valid <= data_valid_nxt;
      frame_done <= frame_done_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_gc_rx.sv
// Bench for gc_rx: pulse-train stimulus scored against a pulse-level model of
// the bit/byte/frame rules, including strobe timing windows.
module tb_gc_rx;

  localparam int ONE_MAX = 100;
  localparam int LOW_MAX = 250;
  localparam int IDLE    = 250;
  localparam int K_DV    = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_in = 1'b1;
  logic       tx_active = 1'b0;
  logic [7:0] data;
  logic       data_valid, frame_done, frame_err, busy;

  gc_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_in),
    .tx_active  (tx_active),
    .data       (data),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int kind;
    int b;
    int lo;
    int hi;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];
  int  lows[$], highs[$], falls[$], rises[$];
  int  cyc = 0;
  int  overlap = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (int'(data_valid) + int'(frame_done) + int'(frame_err) > 1) overlap <= overlap + 1;
    if (data_valid) obs.push_back('{K_DV, int'(data), cyc, cyc});
    if (frame_done) obs.push_back('{K_DONE, 0, cyc, cyc});
    if (frame_err)  obs.push_back('{K_ERR, 0, cyc, cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic add_pulse(input int lo, input int hi);
    lows.push_back(lo);
    highs.push_back(hi);
  endtask

  // nominal: 1 us/3 us cells for a 1, 3 us/1 us for a 0; otherwise random widths
  task automatic add_byte(input logic [7:0] b, input bit nominal);
    for (int i = 7; i >= 0; i--) begin
      if (nominal) begin
        if (b[i]) add_pulse(50, 150);
        else      add_pulse(150, 50);
      end else begin
        if (b[i]) add_pulse(int'($urandom_range(99, 10)), int'($urandom_range(120, 5)));
        else      add_pulse(int'($urandom_range(240, 100)), int'($urandom_range(120, 5)));
      end
    end
  endtask

  task automatic add_stop(input int lo);
    add_pulse(lo, IDLE + 30);
  endtask

  task automatic drive_all();
    falls.delete();
    rises.delete();
    @(posedge clk); #1;
    for (int i = 0; i < lows.size(); i++) begin
      line_in = 1'b0;
      falls.push_back(cyc);
      repeat (lows[i]) @(posedge clk);
      #1;
      line_in = 1'b1;
      rises.push_back(cyc);
      repeat (highs[i]) @(posedge clk);
      #1;
    end
  endtask

  // Reference: each low width is a bit, every 8th bit completes a byte, a long
  // high closes the frame (clean only with one stop bit after whole bytes),
  // and an over-long low aborts. Strobes appear 3 clocks after the causing edge.
  task automatic build_model();
    int         nb;
    logic [7:0] acc;
    exp_q.delete();
    nb  = 0;
    acc = 8'h00;
    for (int i = 0; i < lows.size(); i++) begin
      if (lows[i] >= LOW_MAX) begin
        exp_q.push_back('{K_ERR, 0, falls[i] + LOW_MAX, falls[i] + LOW_MAX + 5});
        nb = 0;
        continue;
      end
      acc = {acc[6:0], (lows[i] < ONE_MAX) ? 1'b1 : 1'b0};
      nb++;
      if (nb % 8 == 0) exp_q.push_back('{K_DV, int'(acc), rises[i] + 3, rises[i] + 3});
      if (highs[i] >= IDLE) begin
        exp_q.push_back('{(nb % 8 == 1) ? K_DONE : K_ERR, 0, rises[i] + IDLE, rises[i] + IDLE + 5});
        nb = 0;
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int base, ov0, n;
    base = obs.size();
    ov0  = overlap;
    drive_all();
    repeat (10) @(posedge clk);
    build_model();
    check({tag, "_events"}, obs.size() - base, exp_q.size());
    n = (obs.size() - base < exp_q.size()) ? obs.size() - base : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, obs[base + i].kind, exp_q[i].kind);
      if (exp_q[i].kind == K_DV) check({tag, "_byte"}, obs[base + i].b, exp_q[i].b);
      check({tag, "_time_in_window"},
            (obs[base + i].lo >= exp_q[i].lo && obs[base + i].lo <= exp_q[i].hi) ? 1 : 0, 1);
    end
    check({tag, "_overlap"}, overlap - ov0, 0);
    lows.delete();
    highs.delete();
  endtask

  initial begin
    int base, busy_hi, nbytes;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_fd", frame_done, 0);
    check("rst_fe", frame_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // 0x41 with nominal cells and a 1 us stop
    add_byte(8'h41, 1'b1);
    add_stop(50);
    run_frame("b41");

    // Three-byte reply with a 2 us stop
    add_byte(8'h40, 1'b0);
    add_byte(8'h03, 1'b0);
    add_byte(8'h00, 1'b0);
    add_stop(100);
    run_frame("three");

    // Width boundaries: 99 -> 1, 100 -> 0, 249 -> 0
    add_pulse(99, 50);
    for (int i = 0; i < 6; i++) add_pulse(100, 50);
    add_pulse(249, 50);
    add_stop(50);
    run_frame("bound");

    // Truncated frame, then a stuck-low line
    for (int i = 0; i < 5; i++) add_pulse(int'($urandom_range(240, 10)), int'($urandom_range(120, 5)));
    highs[4] = IDLE + 30;
    add_pulse(250, IDLE + 30);
    run_frame("errs");
    @(negedge clk);
    check("busy_after_err", busy, 0);

    // Local transmitter takes the line mid-byte
    base = obs.size();
    for (int i = 0; i < 3; i++) add_pulse(int'($urandom_range(240, 10)), int'($urandom_range(120, 5)));
    drive_all();
    @(negedge clk);
    check("busy_pre_tx", busy, 1);
    tx_active = 1'b1;
    busy_hi = 0;
    repeat (300) begin
      @(posedge clk); #1;
      line_in = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (busy) busy_hi++;
    end
    @(posedge clk); #1;
    line_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tx_active = 1'b0;
    repeat (IDLE + 20) @(posedge clk);
    check("tx_events", obs.size() - base, 0);
    check("tx_busy_cycles", busy_hi, 0);
    lows.delete();
    highs.delete();
    add_byte(8'h5A, 1'b1);
    add_stop(50);
    run_frame("after_tx");

    // Reset mid-byte
    base = obs.size();
    for (int i = 0; i < 4; i++) add_pulse(int'($urandom_range(240, 10)), int'($urandom_range(120, 5)));
    drive_all();
    @(negedge clk);
    check("busy_pre_rst", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_data", data, 8'h00);
    check("midrst_dv", data_valid, 0);
    check("midrst_fd", frame_done, 0);
    check("midrst_fe", frame_err, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (IDLE + 20) @(posedge clk);
    check("rst_events", obs.size() - base, 0);
    lows.delete();
    highs.delete();
    add_byte(8'hFF, 1'b0);
    add_stop(int'($urandom_range(120, 30)));
    run_frame("after_rst");

    // Random frames, one of them killed by an over-long low
    for (int f = 0; f < 3; f++) begin
      nbytes = int'($urandom_range(2, 1));
      for (int k = 0; k < nbytes; k++) add_byte(8'($urandom), 1'b0);
      if (f == 1) add_pulse(int'($urandom_range(300, 250)), IDLE + 30);
      else        add_stop(int'($urandom_range(240, 10)));
    end
    run_frame("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gc_rx.md
# gc_rx

Receiver for the N64/GameCube single-wire serial line. It is the receive counterpart of `gc_pulse`. It oversamples the open-drain data line with the system clock and classifies each low pulse by width: under 2 µs is a 1, 2 µs or more is a 0. It assembles the bits MSB-first into bytes and flags the end of a frame after the stop bit. It sits beside `gc_pulse` on the shared bidirectional line and decodes console commands and controller replies. While our own transmitter drives the line, the receiver is gated off.

## Interface
Parameters:
- `CLK_PER_US`, default 50: system clocks per microsecond.
- `ONE_MAX_CLK`, default 2*CLK_PER_US: a low width strictly below this decodes as 1; at or above it decodes as 0.
- `LOW_MAX_CLK`, default 5*CLK_PER_US: a low width reaching this value is a line fault.
- `IDLE_CLK`, default 5*CLK_PER_US: a high time reaching this value ends the frame.

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `line_in`, in, 1: raw data line, asynchronous; idle high.
- `tx_active`, in, 1: high while the local transmitter owns the line (the `transmitting` output of `gc_pulse`).
- `data`, out, 8: last completed byte, MSB first on the wire.
- `data_valid`, out, 1: one-cycle strobe; `data` is new.
- `frame_done`, out, 1: one-cycle strobe; the frame ended cleanly after the stop bit.
- `frame_err`, out, 1: one-cycle strobe; the frame aborted.
- `busy`, out, 1: high from the first falling edge of a frame until it ends or aborts.

## Operation
- `line_in` passes through a 2-flop synchronizer to give `line_s`. All decisions use `line_s`. A falling edge is `line_s`=0 with the previous `line_s`=1.
- Counter `cnt`: wide enough for max(LOW_MAX_CLK, IDLE_CLK), 9 bits at the defaults. It saturates and never wraps.
- Bit counter `bit_cnt` (3 bits) and shift register `sr` (8 bits).
- States:
  - **IDLE**: `busy`=0. A falling edge on `line_s` with `tx_active`=0 moves to LOW, sets `cnt`=1 and `bit_cnt`=0.
  - **LOW**: `cnt` increments each cycle that `line_s`=0.
    - If `cnt` reaches LOW_MAX_CLK: pulse `frame_err`, go to IDLE.
    - On `line_s`=1: decode bit = (`cnt` < ONE_MAX_CLK). Then `sr` <= {sr[6:0], bit} and `bit_cnt`++.
    - If `bit_cnt` was 7: `data` <= {sr[6:0], bit}, pulse `data_valid`, `bit_cnt` wraps to 0.
    - Set `cnt`=1 and go to HIGH.
  - **HIGH**: `cnt` increments each cycle that `line_s`=1.
    - A falling edge moves to LOW with `cnt`=1.
    - If `cnt` reaches IDLE_CLK, the last pulse was the stop bit. If `bit_cnt`==1: pulse `frame_done`. Otherwise pulse `frame_err`. Either way, go to IDLE.
- The stop-bit pulse is the bit shifted after the last byte. Its decoded value is ignored and never reaches `data`. A 1 µs console stop and a 2 µs controller stop are both accepted.
- `tx_active`=1 in any state forces IDLE immediately, with no strobes, and clears `bit_cnt` and `cnt`. `data` is held.
- Simultaneous events:
  - `tx_active` takes priority over everything.
  - The LOW_MAX abort takes priority over the rising edge seen in the same cycle.
  - A falling edge and IDLE_CLK expiry in the same cycle: the timeout wins.
- At most one of `data_valid`, `frame_done`, `frame_err` is high in any cycle.

## Timing
- Reset values: `data`=8'h00, `data_valid`=0, `frame_done`=0, `frame_err`=0, `busy`=0, state IDLE, `sr`=0, `bit_cnt`=0, `cnt`=0, both synchronizer flops=1.
- Latency from a `line_in` rising edge to `data_valid`: 3 clocks (2 synchronizer stages plus 1 registered output).
- `frame_done` or `frame_err` from a timeout asserts 3 clocks after `line_s` has been high for IDLE_CLK cycles.
- All strobes are registered and last exactly one cycle.
- Decode boundaries at the defaults (50 MHz):
  - Low of 99 clocks: 1.
  - Low of 100 clocks: 0.
  - 250 consecutive low clocks: error.
- Reset asserted mid-frame clears immediately; no strobe is emitted on release.

## Test plan
- Send 0x41 as 1 µs/3 µs and 3 µs/1 µs cells, then a 1 µs stop and idle high → `data_valid` once with `data`=0x41, then `frame_done` about 5 µs after the stop rising edge.
- Send a three-byte frame 0x40 0x03 0x00 plus stop → three `data_valid` strobes in order, then one `frame_done`, with no `frame_err`.
- Low pulses of 99 and 100 clocks → decoded 1 and 0 respectively. Check via the byte value 0x80 (first bit 99 clocks, remaining seven bits 100 clocks).
- Five bits, then idle → `frame_err`, no `data_valid`. Then hold the line low 250 clocks → `frame_err`, `busy` falls.
- Raise `tx_active` mid-byte while toggling the line → no strobes, `busy`=0. A clean frame afterwards decodes correctly.
- Assert `rst_n`=0 mid-byte, release, then send 0xFF plus stop → only that byte is reported, and all outputs read their reset values while reset is held.
